// File: rtl/uart_pkg.sv
// Shared types, oversampling constants and parity helpers for the configurable UART.
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    typedef enum logic [1:0] {PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10} parity_e;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

    // The reserved cfg code 2'b11 behaves as no parity.
    function automatic parity_e decode_parity(input logic [1:0] cfg);
        case (cfg)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

    // Callers zero-extend narrow characters so the unused bits do not disturb the XOR.
    function automatic logic calc_parity(input logic [7:0] data, input parity_e mode);
        return (mode == PAR_ODD) ? ~(^data) : ^data;
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a combinational head; the owner qualifies push so it never overflows.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/uart_fifo_core.sv
// Full-duplex UART: runtime baud/parity/stop, 16x oversampled RX, FIFO-buffered both ways.
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               cfg_baud,
    input  logic [1:0]                cfg_parity,
    input  logic                      cfg_stop2,
    input  logic                      tx_valid,
    input  logic [DATA_W-1:0]         tx_data,
    output logic                      tx_ready,
    output logic                      rx_valid,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      rx_frame_err,
    output logic                      rx_parity_err,
    input  logic                      rx_ready,
    output logic                      rx_overrun,
    output logic                      tx_busy,
    output logic                      rx_busy,
    output logic [$clog2(TX_DEPTH):0] tx_level,
    output logic [$clog2(RX_DEPTH):0] rx_level,
    input  logic                      rx,
    output logic                      tx
);
    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    // Tick generator: free-running, cfg_baud of 0 behaves as 1.
    logic [15:0] baud_cnt, baud_max;
    logic        tick;

    assign baud_max = (cfg_baud == 16'd0) ? 16'd0 : cfg_baud - 16'd1;
    assign tick     = (baud_cnt >= baud_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) baud_cnt <= '0;
        else     baud_cnt <= tick ? '0 : baud_cnt + 16'd1;
    end

    // TX path
    logic [DATA_W-1:0] tx_head, tx_shreg;
    logic              tx_full, tx_empty, tx_pop, tx_bit_end;
    logic              tx_par_en, tx_par_bit, tx_stop2;
    logic [4:0]        tx_tcnt;
    logic [BW-1:0]     tx_bit;
    tx_state_e         tx_state;

    assign tx_ready   = !tx_full;
    assign tx_busy    = (tx_state != TX_IDLE);
    assign tx_bit_end = tick && (tx_tcnt == ((tx_state == TX_STOP && tx_stop2) ?
                                 5'(2*OVERSAMPLE-1) : 5'(OVERSAMPLE-1)));
    assign tx_pop     = tick && !tx_empty &&
                        (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_bit_end));

    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_valid && tx_ready), .wdata(tx_data),
        .pop(tx_pop), .rdata(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state   <= TX_IDLE;
            tx         <= 1'b1;
            tx_tcnt    <= '0;
            tx_bit     <= '0;
            tx_shreg   <= '0;
            tx_par_en  <= 1'b0;
            tx_par_bit <= 1'b0;
            tx_stop2   <= 1'b0;
        end else begin
            if (tick && tx_state != TX_IDLE)
                tx_tcnt <= tx_bit_end ? '0 : tx_tcnt + 5'd1;
            // Configuration is captured per frame at the pop.
            if (tx_pop) begin
                tx_state   <= TX_START;
                tx         <= 1'b0;
                tx_tcnt    <= '0;
                tx_shreg   <= tx_head;
                tx_par_en  <= (decode_parity(cfg_parity) != PAR_NONE);
                tx_par_bit <= calc_parity(8'(tx_head), decode_parity(cfg_parity));
                tx_stop2   <= cfg_stop2;
            end else if (tx_bit_end) begin
                case (tx_state)
                    TX_START: begin
                        tx_state <= TX_DATA;
                        tx       <= tx_shreg[0];
                        tx_bit   <= '0;
                    end
                    TX_DATA: begin
                        if (tx_bit == LAST_BIT) begin
                            tx_state <= tx_par_en ? TX_PARITY : TX_STOP;
                            tx       <= tx_par_en ? tx_par_bit : 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_shreg <= tx_shreg >> 1;
                            tx       <= tx_shreg[1];
                        end
                    end
                    TX_PARITY: begin
                        tx_state <= TX_STOP;
                        tx       <= 1'b1;
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    // RX path: two sync flops plus one history flop for edge detection.
    logic [2:0]          rx_sync;
    logic                rx_s, rx_fall, rx_sample, rx_push, rx_pop, rx_full, rx_empty;
    logic                rx_par_err;
    logic [3:0]          rx_tcnt;
    logic [BW-1:0]       rx_bit;
    logic [DATA_W-1:0]   rx_shreg;
    logic [DATA_W+1:0]   rx_head;
    parity_e             rx_par_mode;
    rx_state_e           rx_state;

    assign rx_s      = rx_sync[1];
    assign rx_fall   = rx_sync[2] && !rx_sync[1];
    assign rx_sample = tick && (rx_tcnt == ((rx_state == RX_START) ?
                                4'(MID_SAMPLE-1) : 4'(OVERSAMPLE-1)));
    assign rx_push   = (rx_state == RX_STOP) && rx_sample;
    assign rx_valid  = !rx_empty;
    assign rx_pop    = rx_valid && rx_ready;
    assign rx_busy   = (rx_state != RX_IDLE);
    assign {rx_parity_err, rx_frame_err, rx_data} = rx_head;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    uart_sync_fifo #(.WIDTH(DATA_W+2), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push && (!rx_full || rx_pop)),
        .wdata({rx_par_err, ~rx_s, rx_shreg}), .pop(rx_pop), .rdata(rx_head),
        .full(rx_full), .empty(rx_empty), .level(rx_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync     <= '1;
            rx_state    <= RX_IDLE;
            rx_tcnt     <= '0;
            rx_bit      <= '0;
            rx_shreg    <= '0;
            rx_par_mode <= PAR_NONE;
            rx_par_err  <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            rx_sync    <= {rx_sync[1:0], rx};
            rx_overrun <= rx_push && rx_full && !rx_pop;
            if (tick && rx_state != RX_IDLE)
                rx_tcnt <= rx_sample ? '0 : rx_tcnt + 4'd1;
            case (rx_state)
                RX_IDLE: if (rx_fall) begin
                    rx_state    <= RX_START;
                    rx_tcnt     <= '0;
                    rx_bit      <= '0;
                    rx_par_err  <= 1'b0;
                    rx_par_mode <= decode_parity(cfg_parity);
                end
                RX_START: if (rx_sample) rx_state <= rx_s ? RX_IDLE : RX_DATA;
                RX_DATA: if (rx_sample) begin
                    rx_shreg <= {rx_s, rx_shreg[DATA_W-1:1]};
                    if (rx_bit == LAST_BIT)
                        rx_state <= (rx_par_mode != PAR_NONE) ? RX_PARITY : RX_STOP;
                    else
                        rx_bit <= rx_bit + 1'b1;
                end
                RX_PARITY: if (rx_sample) begin
                    rx_par_err <= (rx_s != calc_parity(8'(rx_shreg), rx_par_mode));
                    rx_state   <= RX_STOP;
                end
                RX_STOP: if (rx_sample) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core: expected RX entries are queued as frames are sent and
// checked by a monitor as the FIFO head is popped.
module tb_uart_fifo_core;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_baud;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;
    logic [7:0]  tx_data, rx_data;
    logic        rx_frame_err, rx_parity_err, rx_overrun, tx_busy, rx_busy;
    logic [4:0]  tx_level, rx_level;
    logic        rx, tx;
    logic        rx_drv, loopback, acc;
    int          checks = 0, errors = 0, ovr_cnt = 0, n_acc;
    logic [9:0]  exp_q[$];

    assign rx = loopback ? tx : rx_drv;
    always #5 clk = ~clk;

    uart_fifo_core #(.DATA_W(8), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .cfg_baud(cfg_baud), .cfg_parity(cfg_parity),
        .cfg_stop2(cfg_stop2), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_frame_err(rx_frame_err),
        .rx_parity_err(rx_parity_err), .rx_ready(rx_ready), .rx_overrun(rx_overrun),
        .tx_busy(tx_busy), .rx_busy(rx_busy), .tx_level(tx_level), .rx_level(rx_level),
        .rx(rx), .tx(tx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (rx_overrun === 1'b1) ovr_cnt++;
            if (!rst && rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected actual=%0h expected=none",
                             {rx_parity_err, rx_frame_err, rx_data});
                end else begin
                    e = exp_q.pop_front();
                    check("rx_entry", {rx_parity_err, rx_frame_err, rx_data}, e);
                end
            end
        end
    endtask

    task automatic push(input logic [7:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        rx_drv = b;
        repeat (16) @(posedge clk);
        #1;
    endtask

    // pmode: 0 none, 1 even, 2 odd; inv flips the parity bit actually sent.
    task automatic drive_frame(input logic [7:0] d, input int pmode, input logic inv,
                               input logic stopv);
        logic p;
        p = ^d;
        if (pmode == 2) p = ~p;
        if (inv) p = ~p;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pmode != 0) send_bit(p);
        send_bit(stopv);
        send_bit(1'b1);
    endtask

    // bits[0] is the start bit; each later bit is sampled mid-bit, 16 clocks apart.
    task automatic tx_watch(input string name, input logic [11:0] bits, input int n);
        int w, k;
        w = 0;
        while (tx !== 1'b0 && w < 100) begin @(negedge clk); w++; end
        check({name, "_start_seen"}, (w < 100), 1);
        k = 0;
        while (tx === 1'b0 && k < 40) begin @(negedge clk); k++; end
        check({name, "_start_len"}, k, 16);
        repeat (8) @(negedge clk);
        for (int b = 1; b < n; b++) begin
            check($sformatf("%s_bit%0d", name, b), tx, bits[b]);
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string name);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || rx_valid) && w < 2000) begin @(negedge clk); w++; end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; cfg_baud = 16'd1; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b1; rx_drv = 1'b1; loopback = 1'b0;
        fork monitor(); join_none
        repeat (3) @(posedge clk); #1;
        check("rst_tx", tx, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_levels", {tx_level, rx_level}, 0);
        check("rst_busy", {tx_busy, rx_busy, rx_overrun}, 0);
        rst = 1'b0;

        // Reset in the middle of a 0x00 frame must raise tx immediately.
        push(8'h00);
        repeat (40) @(negedge clk);
        check("midframe_tx_low", tx, 0);
        rst = 1'b1;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_state", {tx_busy, tx_ready, rx_valid}, 3'b010);
        check("midrst_levels", {tx_level, rx_level}, 0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;

        // 8N1 loopback of 0xA5.
        loopback = 1'b1;
        exp_q.push_back({2'b00, 8'hA5});
        push(8'hA5);
        tx_watch("a5", {1'b1, 1'b1, 1'b1, 8'hA5, 1'b0}, 10);
        wait_drain("drain_a5");

        // Even parity loopback of 0x07: parity bit is 1.
        cfg_parity = 2'b01;
        exp_q.push_back({2'b00, 8'h07});
        push(8'h07);
        tx_watch("p07", {1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        wait_drain("drain_p07");

        // Corrupted parity bit from the bench.
        loopback = 1'b0;
        exp_q.push_back({2'b10, 8'h07});
        drive_frame(8'h07, 1, 1'b1, 1'b1);
        wait_drain("drain_parerr");

        // Frame error followed by a clean frame.
        cfg_parity = 2'b00;
        exp_q.push_back({2'b01, 8'h3C});
        drive_frame(8'h3C, 0, 1'b0, 1'b0);
        exp_q.push_back({2'b00, 8'h5A});
        drive_frame(8'h5A, 0, 1'b0, 1'b1);
        wait_drain("drain_frmerr");

        // TX FIFO limits at a slow baud; first tick lands ~1000 clocks after reset.
        rst = 1'b1; cfg_baud = 16'd1000;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        n_acc = 0; tx_valid = 1'b1; tx_data = 8'h10;
        for (int c = 0; c < 100 && n_acc < 16; c++) begin
            @(negedge clk); acc = tx_ready;
            @(posedge clk); #1;
            if (acc) begin n_acc++; tx_data = tx_data + 8'd1; end
        end
        @(negedge clk);
        check("tx_full_ready", {tx_ready, tx_busy}, 2'b00);
        check("tx_full_level", tx_level, 16);
        for (int c = 0; c < 3000 && n_acc < 17; c++) begin
            @(negedge clk); acc = tx_ready;
            @(posedge clk); #1;
            if (acc) begin n_acc++; tx_data = tx_data + 8'd1; end
        end
        repeat (20) @(negedge clk);
        check("tx_accepted", n_acc, 17);
        check("tx_after17_ready", tx_ready, 0);
        check("tx_after17_level", tx_level, 16);
        check("tx_after17_line", {tx_busy, tx}, 2'b10);
        tx_valid = 1'b0;

        // RX overrun: 17 frames with no pops.
        rst = 1'b1; cfg_baud = 16'd1;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        rx_ready = 1'b0; ovr_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({2'b00, 8'h40 + 8'(i)});
            drive_frame(8'h40 + 8'(i), 0, 1'b0, 1'b1);
        end
        check("ovr_none_16", ovr_cnt, 0);
        check("rx_level_16", rx_level, 16);
        drive_frame(8'h50, 0, 1'b0, 1'b1);
        check("ovr_pulse", ovr_cnt, 1);
        check("rx_level_after_ovr", rx_level, 16);
        check("rx_head_after_ovr", rx_data, 8'h40);
        rx_ready = 1'b1;
        wait_drain("drain_ovr");

        // 4-clock low glitch is a false start.
        @(posedge clk); #1;
        rx_drv = 1'b0;
        repeat (4) @(posedge clk); #1;
        rx_drv = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy", rx_busy, 1);
        repeat (30) @(negedge clk);
        check("glitch_idle", {rx_busy, rx_valid}, 2'b00);
        check("glitch_level", rx_level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
